// File: rtl/mig_seq_pkg.sv
// Shared definitions for the MIG power-up / recovery sequencer:
// state encoding (also the o_State debug value) and retry counter width.
package mig_seq_pkg;

    localparam logic [2:0] ST_WAIT_LOCK  = 3'd0;
    localparam logic [2:0] ST_HOLD_RESET = 3'd1;
    localparam logic [2:0] ST_WAIT_CALIB = 3'd2;
    localparam logic [2:0] ST_RUNNING    = 3'd3;
    localparam logic [2:0] ST_FAULT      = 3'd4;

    localparam int RETRY_W = 2;

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous single-bit
// level signals; each bit is synchronized independently.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; the first stage may go metastable and is never used directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mig_init_sequencer.sv
// Power-up and recovery sequencer for the DDR MIG: lock filter, reset hold,
// calibration wait with bounded retries. Optional MIG_LOCK_LOSS_RECOVERY_EN.
module mig_init_sequencer
    import mig_seq_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH        = 24,
    parameter int unsigned LOCK_FILTER_CYCLES   = 256,
    parameter int unsigned HOLD_CYCLES          = 40000,
    parameter int unsigned CALIB_TIMEOUT_CYCLES = 4000000,
    parameter int unsigned MAX_RETRIES          = 3
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               i_Pll_Locked,
    input  logic               i_Init_Calib_Complete,
    output logic               o_Mig_Reset,
    output logic               o_System_Ready,
    output logic               o_Fault,
    output logic [RETRY_W-1:0] o_Retry_Count,
    output logic [2:0]         o_State
);

    localparam longint unsigned CNT_LIMIT = 64'd1 << COUNTER_WIDTH;

    if ((LOCK_FILTER_CYCLES == 32'd0) || (64'(LOCK_FILTER_CYCLES) >= CNT_LIMIT)) begin : g_bad_lock
        $error("LOCK_FILTER_CYCLES must be nonzero and fit in COUNTER_WIDTH");
    end
    if ((HOLD_CYCLES == 32'd0) || (64'(HOLD_CYCLES) >= CNT_LIMIT)) begin : g_bad_hold
        $error("HOLD_CYCLES must be nonzero and fit in COUNTER_WIDTH");
    end
    if ((CALIB_TIMEOUT_CYCLES == 32'd0) || (64'(CALIB_TIMEOUT_CYCLES) >= CNT_LIMIT)) begin : g_bad_calib
        $error("CALIB_TIMEOUT_CYCLES must be nonzero and fit in COUNTER_WIDTH");
    end
    if (MAX_RETRIES >= (32'd1 << RETRY_W)) begin : g_bad_retry
        $error("MAX_RETRIES must fit in the retry counter");
    end

    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO   = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE    = COUNTER_WIDTH'(32'd1);
    localparam logic [COUNTER_WIDTH-1:0] LOCK_LAST  = COUNTER_WIDTH'(LOCK_FILTER_CYCLES - 32'd1);
    localparam logic [COUNTER_WIDTH-1:0] HOLD_LAST  = COUNTER_WIDTH'(HOLD_CYCLES - 32'd1);
    localparam logic [COUNTER_WIDTH-1:0] CALIB_LAST = COUNTER_WIDTH'(CALIB_TIMEOUT_CYCLES - 32'd1);
    localparam logic [RETRY_W-1:0]       RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0]       RETRY_ONE  = RETRY_W'(32'd1);

    logic [1:0]               sync_s;
    logic                     lock_s;
    logic                     calib_s;
    logic                     timeout_s;

    logic [2:0]               state_q;
    logic [2:0]               state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;
    logic [RETRY_W-1:0]       retry_q;
    logic [RETRY_W-1:0]       retry_d;
    logic                     mig_rst_q;
    logic                     ready_q;
    logic                     fault_q;

    sync_2ff #(
        .WIDTH (2)
    ) u_sync (
        .clk_i (i_Clock),
        .rst_i (i_Reset),
        .d_i   ({i_Init_Calib_Complete, i_Pll_Locked}),
        .q_o   (sync_s)
    );

    assign lock_s  = sync_s[0];
    assign calib_s = sync_s[1];

    // Next-state, shared counter and retry bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        timeout_s = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d = ST_HOLD_RESET;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_HOLD_RESET: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_CALIB;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_CALIB: begin
                // Lock loss beats calibration, which beats timeout.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (calib_s) begin
                    state_d = ST_RUNNING;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CALIB_LAST) begin
                    timeout_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUNNING: begin
`ifdef MIG_LOCK_LOSS_RECOVERY_EN
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (!calib_s) begin
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_RUNNING;
                end
`else
                if (!calib_s) begin
                    timeout_s = 1'b1;
                end else begin
                    state_d = ST_RUNNING;
                end
`endif
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // A calibration loss in RUNNING is handled exactly like a timeout.
        if (timeout_s) begin
            cnt_d = CNT_ZERO;
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FAULT;
            end else begin
                retry_d = retry_q + RETRY_ONE;
                state_d = ST_HOLD_RESET;
            end
        end else begin
            retry_d = retry_q;
        end
    end

    // State, counter and outputs; outputs are decoded from the next state so they track o_State.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= CNT_ZERO;
            retry_q   <= {RETRY_W{1'b0}};
            mig_rst_q <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            mig_rst_q <= (state_d == ST_WAIT_CALIB) || (state_d == ST_RUNNING);
            ready_q   <= (state_d == ST_RUNNING);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    assign o_Mig_Reset    = mig_rst_q;
    assign o_System_Ready = ready_q;
    assign o_Fault        = fault_q;
    assign o_Retry_Count  = retry_q;
    assign o_State        = state_q;

endmodule

// File: tb/tb_mig_init_sequencer.sv
// Self-checking bench for mig_init_sequencer with small timing parameters:
// directed bring-up/recovery scenarios followed by randomized lock/calib activity.
module tb_mig_init_sequencer;

    localparam int unsigned CW = 8;
    localparam int unsigned LF = 4;
    localparam int unsigned HC = 8;
    localparam int unsigned CT = 20;
    localparam int unsigned MR = 2;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       lock_in;
    logic       calib_in;
    logic       mig_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry;
    logic [2:0] state;

    always #5 clk = ~clk;

    mig_init_sequencer #(
        .COUNTER_WIDTH        (CW),
        .LOCK_FILTER_CYCLES   (LF),
        .HOLD_CYCLES          (HC),
        .CALIB_TIMEOUT_CYCLES (CT),
        .MAX_RETRIES          (MR)
    ) dut (
        .i_Clock               (clk),
        .i_Reset               (rst_in),
        .i_Pll_Locked          (lock_in),
        .i_Init_Calib_Complete (calib_in),
        .o_Mig_Reset           (mig_rst),
        .o_System_Ready        (ready),
        .o_Fault               (fault),
        .o_Retry_Count         (retry),
        .o_State               (state)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase is the externally visible state number.
    int   m_phase;
    int   m_streak;
    int   m_held;
    int   m_waited;
    int   m_retries;
    logic m_lock_dly [2];
    logic m_cal_dly  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_timeout();
        if (m_retries == int'(MR)) begin
            m_phase = 4;
        end else begin
            m_retries++;
            m_phase = 1;
            m_held  = 0;
        end
    endtask

    task automatic go_wait_lock();
        m_phase  = 0;
        m_streak = 0;
    endtask

    task automatic model_step();
        logic ls;
        logic cs;
        if (rst_in) begin
            go_wait_lock();
            m_retries     = 0;
            m_lock_dly[0] = 1'b0;
            m_lock_dly[1] = 1'b0;
            m_cal_dly[0]  = 1'b0;
            m_cal_dly[1]  = 1'b0;
        end else begin
            // Inputs become visible to the sequencer two clocks after sampling.
            ls            = m_lock_dly[1];
            cs            = m_cal_dly[1];
            m_lock_dly[1] = m_lock_dly[0];
            m_cal_dly[1]  = m_cal_dly[0];
            m_lock_dly[0] = lock_in;
            m_cal_dly[0]  = calib_in;
            case (m_phase)
                0: begin
                    m_streak = ls ? m_streak + 1 : 0;
                    if (m_streak == int'(LF)) begin
                        m_phase = 1;
                        m_held  = 0;
                    end
                end
                1: begin
                    if (!ls) go_wait_lock();
                    else begin
                        m_held++;
                        if (m_held == int'(HC)) begin
                            m_phase  = 2;
                            m_waited = 0;
                        end
                    end
                end
                2: begin
                    if (!ls) go_wait_lock();
                    else if (cs) m_phase = 3;
                    else begin
                        m_waited++;
                        if (m_waited == int'(CT)) model_timeout();
                    end
                end
                3: begin
`ifdef MIG_LOCK_LOSS_RECOVERY_EN
                    if (!ls) go_wait_lock();
                    else if (!cs) model_timeout();
`else
                    if (!cs) model_timeout();
`endif
                end
                default: m_phase = 4;
            endcase
        end
    endtask

    // One clock: advance the model at the edge, compare every output mid-cycle.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("cyc_state", state, m_phase);
        chk("cyc_mig_reset", mig_rst, (m_phase == 2 || m_phase == 3) ? 1 : 0);
        chk("cyc_ready", ready, (m_phase == 3) ? 1 : 0);
        chk("cyc_fault", fault, (m_phase == 4) ? 1 : 0);
        chk("cyc_retry", retry, m_retries);
    endtask

    task automatic run_until_state(input logic [2:0] s, input int bound, input string nm);
        int n;
        n = 0;
        while (state !== s && n < bound) begin
            cyc();
            n++;
        end
        chk(nm, state, s);
    endtask

    task automatic count_hold(input string nm);
        int h;
        h = 0;
        while (state === 3'd1 && h < 50) begin
            cyc();
            h++;
        end
        chk(nm, h, HC);
        chk({nm, "_released"}, mig_rst, 1);
    endtask

    initial begin
        int n;
        int entries;
        logic [2:0] prev;

        rst_in   = 1'b1;
        lock_in  = 1'b0;
        calib_in = 1'b0;
        repeat (3) cyc();
        chk("reset_state", state, 0);
        chk("reset_mig", mig_rst, 0);
        chk("reset_ready", ready, 0);
        chk("reset_fault", fault, 0);
        chk("reset_retry", retry, 0);

        // Nominal bring-up
        rst_in  = 1'b0;
        lock_in = 1'b1;
        run_until_state(3'd1, 30, "nom_enter_hold");
        count_hold("nom_hold_len");
        repeat (4) cyc();
        calib_in = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("nom_ready_latency", n, 3);
        chk("nom_state", state, 3);
        chk("nom_retry", retry, 0);

        // Calibration loss while running, then lock loss at hold count 5
        calib_in = 1'b0;
        n = 0;
        while (ready !== 1'b0 && n < 10) begin
            cyc();
            n++;
        end
        chk("drop_ready_latency", n, 3);
        chk("drop_retry", retry, 1);
        chk("drop_state", state, 1);
        repeat (3) cyc();
        lock_in = 1'b0;
        cyc();
        lock_in = 1'b1;
        cyc();
        chk("hold_before_drop", state, 1);
        cyc();
        chk("hold_lock_drop", state, 0);
        chk("hold_drop_retry", retry, 1);
        run_until_state(3'd1, 30, "relock_hold");
        count_hold("relock_hold_len");
        chk("relock_retry", retry, 1);
        calib_in = 1'b1;
        run_until_state(3'd3, 30, "recover_running");

        // Lock loss while running
        lock_in = 1'b0;
        repeat (10) cyc();
`ifdef MIG_LOCK_LOSS_RECOVERY_EN
        chk("runlock_state", state, 0);
        chk("runlock_mig", mig_rst, 0);
        chk("runlock_ready", ready, 0);
`else
        chk("runlock_state", state, 3);
        chk("runlock_mig", mig_rst, 1);
        chk("runlock_ready", ready, 1);
`endif
        lock_in = 1'b1;
        run_until_state(3'd3, 80, "runlock_recover");
        chk("runlock_retry", retry, 1);

        // Glitchy lock after reset
        rst_in = 1'b1;
        cyc();
        rst_in   = 1'b0;
        lock_in  = 1'b0;
        calib_in = 1'b0;
        repeat (3) cyc();
        lock_in = 1'b1;
        repeat (3) cyc();
        lock_in = 1'b0;
        cyc();
        lock_in = 1'b1;
        n = 0;
        while (state !== 3'd1 && n < 30) begin
            cyc();
            n++;
        end
        chk("glitch_filter_len", n, 6);

        // Calibration never completes: two retries, then fault
        entries = 1;
        prev    = state;
        n       = 0;
        while (fault !== 1'b1 && n < 400) begin
            cyc();
            if (state === 3'd1 && prev !== 3'd1) entries++;
            prev = state;
            n++;
        end
        chk("fault_flag", fault, 1);
        chk("fault_state", state, 4);
        chk("fault_mig", mig_rst, 0);
        chk("fault_retry", retry, 2);
        chk("fault_hold_entries", entries, 3);
        chk("model_fault_phase", m_phase, 4);
        lock_in = 1'b0;
        repeat (5) cyc();
        chk("fault_sticky", fault, 1);
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        chk("clear_state", state, 0);
        chk("clear_fault", fault, 0);
        chk("clear_retry", retry, 0);
        chk("clear_mig", mig_rst, 0);
        chk("clear_ready", ready, 0);

        // Randomized lock/calibration activity with occasional reset
        for (int i = 0; i < 4000; i++) begin
            if (lock_in ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0))
                lock_in = ~lock_in;
            if (calib_in ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 9) == 0))
                calib_in = ~calib_in;
            rst_in = ($urandom_range(0, 249) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
